// File: rtl/conv_2_mac_if.sv
// conv_2 MAC back-end bus: operand/bias stream in, output BRAM write port
// and run status out.
interface conv_2_mac_if #(
  parameter int DW     = 16,
  parameter int ADDR_W = 4
);
  logic              start;
  logic              bias_valid;
  logic [DW-1:0]     bias_in;
  logic              term_valid;
  logic [DW-1:0]     weight_in;
  logic [DW-1:0]     fm_in;
  logic              out_bram_we;
  logic [ADDR_W-1:0] out_bram_addr;
  logic [DW-1:0]     out_bram_din;
  logic              busy;
  logic              done;
  logic              sat_flag;

  modport master (
    output start, bias_valid, bias_in,
    output term_valid, weight_in, fm_in,
    input  out_bram_we, out_bram_addr, out_bram_din,
    input  busy, done, sat_flag
  );

  modport slave (
    input  start, bias_valid, bias_in,
    input  term_valid, weight_in, fm_in,
    output out_bram_we, out_bram_addr, out_bram_din,
    output busy, done, sat_flag
  );
endinterface

// File: rtl/conv_2_mac.sv
// conv_2 multiply-accumulate, bias, rescale and saturate per output channel.
// Optional CONV2_RELU_EN: clamp negative channel results to zero.
module conv_2_mac #(
  parameter int TERMS   = 300,
  parameter int NUM_OUT = 8,
  parameter int DW      = 16,
  parameter int FRAC    = 8,
  parameter int ACC_W   = 40,
  parameter int ADDR_W  = 4
) (
  input logic         clk,
  input logic         rst,
  conv_2_mac_if.slave bus
);
  localparam int CNT_W = $clog2(TERMS + 1);
  localparam int PW    = 2 * DW;

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV =
    {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, WAIT_BIAS, ACCUM, DRAIN1,
    DRAIN2, ROUND, WRITE, DONE
  } state_t;

  state_t                   state;
  logic [ADDR_W-1:0]        ch;
  logic [CNT_W-1:0]         term_cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PW-1:0]     prod;
  logic                     prod_vld;
  logic signed [DW-1:0]     bias_q;

  logic signed [ACC_W-1:0]  p_ext;
  logic signed [ACC_W-1:0]  b_ext;
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  shr;
  logic                     clip_hi;
  logic                     clip_lo;
  logic [DW-1:0]            sat_val;
  logic [DW-1:0]            wr_val;

  assign p_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign b_ext = {{(ACC_W-DW){bias_q[DW-1]}}, bias_q};
  assign sum_s = acc + (b_ext <<< FRAC);
  assign shr   = sum_s >>> FRAC;

  assign clip_hi = shr > MAXV;
  assign clip_lo = shr < MINV;

  always_comb begin
    sat_val = shr[DW-1:0];
    if (clip_hi)
      sat_val = {1'b0, {(DW-1){1'b1}}};
    else if (clip_lo)
      sat_val = {1'b1, {(DW-1){1'b0}}};
  end

`ifdef CONV2_RELU_EN
  assign wr_val = sat_val[DW-1] ? '0 : sat_val;
`else
  assign wr_val = sat_val;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      ch                <= '0;
      term_cnt          <= '0;
      acc               <= '0;
      prod              <= '0;
      prod_vld          <= 1'b0;
      bias_q            <= '0;
      bus.out_bram_we   <= 1'b0;
      bus.out_bram_addr <= '0;
      bus.out_bram_din  <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.sat_flag      <= 1'b0;
    end else begin
      prod_vld        <= 1'b0;
      bus.out_bram_we <= 1'b0;
      // accumulate stage trails the multiply stage by one cycle
      if (prod_vld)
        acc <= acc + p_ext;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            ch           <= '0;
            term_cnt     <= '0;
            acc          <= '0;
            bus.sat_flag <= 1'b0;
            bus.done     <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= WAIT_BIAS;
          end
        end
        WAIT_BIAS: begin
          if (bus.bias_valid) begin
            bias_q   <= bus.bias_in;
            acc      <= '0;
            term_cnt <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (bus.term_valid) begin
            prod     <= $signed(bus.weight_in)
                      * $signed(bus.fm_in);
            prod_vld <= 1'b1;
            term_cnt <= term_cnt + 1'b1;
            if (term_cnt == CNT_W'(TERMS - 1))
              state <= DRAIN1;
          end
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: state <= ROUND;
        ROUND: begin
          bus.out_bram_we   <= 1'b1;
          bus.out_bram_addr <= ch;
          bus.out_bram_din  <= wr_val;
          if (clip_hi || clip_lo)
            bus.sat_flag <= 1'b1;
          state <= WRITE;
        end
        WRITE: begin
          ch <= ch + 1'b1;
          if (ch == ADDR_W'(NUM_OUT - 1)) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= DONE;
          end else begin
            state <= WAIT_BIAS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_2_mac.sv
// Scoreboard bench for conv_2_mac: model-predicted channel writes are
// queued by the driver and matched against the BRAM write port.
module tb_conv_2_mac;
  localparam int TERMS   = 300;
  localparam int NUM_OUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_2_mac_if bus ();

  conv_2_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  bit  exp_sat;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  function automatic logic [16:0] model(input longint acc,
                                        input logic [15:0] b);
    longint s, r;
    logic [15:0] v;
    logic c;
    s = acc + longint'($signed(b)) * 256;
    r = s >>> 8;
    c = 1'b0;
    if (r > 32767) begin
      v = 16'h7fff; c = 1'b1;
    end else if (r < -32768) begin
      v = 16'h8000; c = 1'b1;
    end else begin
      v = r[15:0];
    end
`ifdef CONV2_RELU_EN
    if (v[15]) v = 16'h0000;
`endif
    return {c, v};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.out_bram_we === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_we", 1, 0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_addr", bus.out_bram_addr, e.a);
        chk("wr_din", bus.out_bram_din, e.d);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.bias_valid = 1'b0;
    bus.bias_in    = '0;
    bus.term_valid = 1'b0;
    bus.weight_in  = '0;
    bus.fm_in      = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    exp_sat = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, bus.out_bram_we, 0);
    chk({tag, "_addr"}, bus.out_bram_addr, 0);
    chk({tag, "_din"}, bus.out_bram_din, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_sat"}, bus.sat_flag, 0);
  endtask

  // Entered and left #1 after a rising edge.
  task automatic feed_ch(input int ch, input logic [15:0] b,
                         input logic [15:0] w0, input logic [15:0] f0,
                         input bit rnd, input bit gaps, input bit concur,
                         input int nterms, input int start_at);
    longint acc;
    logic [15:0] w, f;
    logic [16:0] m;
    int lat;
    wr_t e;
    acc = 0;
    bus.bias_valid = 1'b1;
    bus.bias_in    = b;
    if (concur) begin
      bus.term_valid = 1'b1;
      bus.weight_in  = 16'h7fff;
      bus.fm_in      = 16'h7fff;
    end
    @(posedge clk);
    #1;
    bus.bias_valid = 1'b0;
    bus.term_valid = 1'b0;
    bus.bias_in    = 16'($urandom);
    for (int i = 0; i < nterms; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.weight_in = 16'($urandom);
          bus.fm_in     = 16'($urandom);
          bus.bias_valid = 1'($urandom);
          @(posedge clk);
          #1 bus.bias_valid = 1'b0;
        end
      end
      w = rnd ? 16'($urandom) : w0;
      f = rnd ? 16'($urandom) : f0;
      bus.term_valid = 1'b1;
      bus.weight_in  = w;
      bus.fm_in      = f;
      bus.start      = (i == start_at);
      acc += longint'($signed(w)) * longint'($signed(f));
      @(posedge clk);
      #1;
      bus.term_valid = 1'b0;
      bus.start      = 1'b0;
    end
    if (nterms < TERMS) return;
    m = model(acc, b);
    exp_sat |= m[16];
    e.a = 4'(ch);
    e.d = m[15:0];
    sb.push_back(e);
    lat = 1;
    while (bus.out_bram_we !== 1'b1 && lat < 20) begin
      bus.term_valid = 1'b1;
      bus.weight_in  = 16'($urandom);
      bus.fm_in      = 16'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    bus.term_valid = 1'b0;
    chk("latency", lat, 4);
    chk("busy_wr", bus.busy, 1);
    chk("done_wr", bus.done, 0);
    chk("sat", bus.sat_flag, exp_sat);
    @(posedge clk);
    #1;
    if (ch == NUM_OUT - 1) begin
      chk("done_rise", bus.done, 1);
      chk("busy_fall", bus.busy, 0);
    end
  endtask

  initial begin
    exp_sat = 1'b0;
    do_reset();
    chk_reset_vals("rst");

    // gain: 300 * 0.0625 * 1.0 = 18.75
    pulse_start();
    feed_ch(0, 16'h0000, 16'h0010, 16'h0100, 0, 0, 0, TERMS, -1);
    chk("gain_sat", bus.sat_flag, 0);
    do_reset();

    pulse_start();
    feed_ch(0, 16'h0000, 16'h0100, 16'h0100, 0, 0, 0, TERMS, -1);
    chk("pos_sat", bus.sat_flag, 1);
    do_reset();

    pulse_start();
    feed_ch(0, 16'h0000, 16'hff00, 16'h0100, 0, 0, 0, TERMS, -1);
    chk("neg_sat", bus.sat_flag, 1);
    do_reset();

    // bubbles plus a term_valid alongside bias_valid that must be dropped
    pulse_start();
    feed_ch(0, 16'h0080, 16'h0100, 16'h0001, 0, 1, 1, TERMS, -1);
    do_reset();

    // full layer with a stray start during channel 2
    pulse_start();
    for (int c = 0; c < NUM_OUT; c++)
      feed_ch(c, 16'(c * 256), 16'h0000, 16'h1234, 0, 0, 0, TERMS,
              (c == 2) ? 100 : -1);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_addr", bus.out_bram_addr, 7);
    chk("hold_din", bus.out_bram_din, 16'h0700);
    chk("done_hold", bus.done, 1);

    // restart from DONE, then abort mid-channel 3
    pulse_start();
    chk("restart_done", bus.done, 0);
    chk("restart_busy", bus.busy, 1);
    for (int c = 0; c < 3; c++)
      feed_ch(c, 16'($urandom), 16'h0, 16'h0, 1, 1, 0, TERMS, -1);
    feed_ch(3, 16'h0100, 16'h0010, 16'h0100, 0, 0, 0, 150, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("abort");
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_vals("abort_rel");
    pulse_start();
    feed_ch(0, 16'h0000, 16'h0010, 16'h0100, 0, 0, 0, TERMS, -1);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
